// File: rtl/soc_boot_ctrl_if.sv
// ---------------------------------------------------------------------------
// soc_boot_ctrl_if
// Handshake/status bundle between a boot master (SoC sequencer, testbench)
// and the soc_boot_ctrl core reset sequencer.
//
// Parameters
//   NUM_CORES   number of cores sequenced
//   CNT_W       width of the run-cycle counter
//
// Signals
//   start        master -> ctrl  one-cycle boot request
//   clr          master -> ctrl  one-cycle return-to-idle request
//   core_done    master -> ctrl  per-core completion level
//   core_rst     ctrl -> master  per-core reset, active-high
//   busy         ctrl -> master  releasing cores or running
//   all_done     ctrl -> master  every core reported completion
//   timeout      ctrl -> master  watchdog expired
//   done_mask    ctrl -> master  sticky per-core completion flags
//   cycle_count  ctrl -> master  cycles elapsed since start
//
// Modports: master (boot requester side), slave (soc_boot_ctrl side).
// ---------------------------------------------------------------------------
interface soc_boot_ctrl_if #(
  parameter int NUM_CORES = 4,
  parameter int CNT_W     = 32
);
  logic                 start;
  logic                 clr;
  logic [NUM_CORES-1:0] core_done;
  logic [NUM_CORES-1:0] core_rst;
  logic                 busy;
  logic                 all_done;
  logic                 timeout;
  logic [NUM_CORES-1:0] done_mask;
  logic [CNT_W-1:0]     cycle_count;

  modport master (
    output start, clr, core_done,
    input  core_rst, busy, all_done, timeout, done_mask, cycle_count
  );

  modport slave (
    input  start, clr, core_done,
    output core_rst, busy, all_done, timeout, done_mask, cycle_count
  );
endinterface

// File: rtl/soc_boot_ctrl.sv
// ---------------------------------------------------------------------------
// soc_boot_ctrl
// Staggered core reset release sequencer with completion tracking and an
// optional watchdog.
//
// On start the cores leave reset one after another, STAGGER_CYCLES apart,
// beginning with core 0. Each core's completion level is latched into
// done_mask once the core is out of reset; when every core has reported the
// controller parks in DONE with the cores still running. cycle_count counts
// cycles spent releasing/running and saturates at all ones.
//
// Optional feature macro: SOC_BOOT_WDT_EN
//   defined   -> watchdog: cycle_count reaching TIMEOUT_CYCLES while
//                releasing/running moves to TMO and puts all cores back in
//                reset (a simultaneous final completion still wins).
//   undefined -> no watchdog, timeout stays 0, RUN lasts until all cores
//                complete or clr.
//
// Ports
//   clk   input  single clock
//   rst   input  asynchronous active-high reset (forces IDLE, all cores in
//                reset, status cleared)
//   bus   soc_boot_ctrl_if.slave  start/clr/core_done in, status out
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module soc_boot_ctrl #(
  parameter int NUM_CORES      = 4,
  parameter int STAGGER_CYCLES = 16,
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic           clk,
  input  logic           rst,
  soc_boot_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RELEASE = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
  localparam logic [2:0] S_TMO     = 3'd4;

  localparam int STG_W = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;
  localparam logic [STG_W-1:0]     STG_LAST = STG_W'(STAGGER_CYCLES - 1);
  localparam logic [NUM_CORES-1:0] ALL_ONES = '1;
  // Pattern of core_rst just before the final release: only the top core held.
  localparam logic [NUM_CORES-1:0] LAST_HELD = ALL_ONES ^ (ALL_ONES >> 1);
  localparam logic [CNT_W-1:0]     CNT_MAX  = '1;

`ifdef SOC_BOOT_WDT_EN
  localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TIMEOUT_CYCLES);
`endif

  // Reject unsupported configurations at elaboration.
  if (NUM_CORES < 1 || NUM_CORES > 16 || STAGGER_CYCLES < 1 ||
      TIMEOUT_CYCLES < 1 ||
      (CNT_W < 63 && longint'(TIMEOUT_CYCLES) >= (longint'(1) << CNT_W)))
  begin : g_bad_cfg
    $error("soc_boot_ctrl: unsupported parameter combination");
  end

  logic [2:0]           state_reg,       state_next;
  logic [NUM_CORES-1:0] core_rst_reg,    core_rst_next;
  logic                 busy_reg,        busy_next;
  logic                 all_done_reg,    all_done_next;
  logic                 timeout_reg,     timeout_next;
  logic [NUM_CORES-1:0] done_mask_reg,   done_mask_next;
  logic [CNT_W-1:0]     cycle_count_reg, cycle_count_next;
  logic [STG_W-1:0]     stg_reg,         stg_next;

  logic [CNT_W-1:0]     cnt_inc;
  logic [NUM_CORES-1:0] mask_upd;

  always_comb begin
    state_next       = state_reg;
    core_rst_next    = core_rst_reg;
    done_mask_next   = done_mask_reg;
    cycle_count_next = cycle_count_reg;
    stg_next         = stg_reg;

    cnt_inc  = (cycle_count_reg == CNT_MAX) ? cycle_count_reg
                                            : cycle_count_reg + 1'b1;
    // Completion is only believed from cores that are currently out of reset.
    mask_upd = done_mask_reg | (bus.core_done & ~core_rst_reg);

    case (state_reg)
      S_IDLE: begin
        if (bus.start) begin
          done_mask_next   = '0;
          cycle_count_next = '0;
          stg_next         = '0;
          // Core 0 leaves reset on this edge; a single-core build has
          // nothing left to stagger and goes straight to RUN.
          core_rst_next    = ALL_ONES << 1;
          state_next       = (NUM_CORES == 1) ? S_RUN : S_RELEASE;
        end
      end

      S_RELEASE, S_RUN: begin
        cycle_count_next = cnt_inc;
        done_mask_next   = mask_upd;

        if (state_reg == S_RELEASE) begin
          if (stg_reg == STG_LAST) begin
            stg_next      = '0;
            core_rst_next = core_rst_reg << 1;
            if (core_rst_reg == LAST_HELD) begin
              state_next = S_RUN;
            end
          end else begin
            stg_next = stg_reg + 1'b1;
          end
        end

        // Completion is checked first so a final done bit arriving on the
        // watchdog cycle still ends in DONE.
        if (mask_upd == ALL_ONES) begin
          state_next = S_DONE;
        end
`ifdef SOC_BOOT_WDT_EN
        else if (cnt_inc >= TMO_LIM) begin
          state_next    = S_TMO;
          core_rst_next = ALL_ONES;
        end
`endif
      end

      default: begin
        // DONE and TMO hold everything until clr.
      end
    endcase

    if (bus.clr) begin
      state_next    = S_IDLE;
      core_rst_next = ALL_ONES;
    end

    busy_next     = (state_next == S_RELEASE) || (state_next == S_RUN);
    all_done_next = (state_next == S_DONE);
    timeout_next  = (state_next == S_TMO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      core_rst_reg    <= ALL_ONES;
      busy_reg        <= 1'b0;
      all_done_reg    <= 1'b0;
      timeout_reg     <= 1'b0;
      done_mask_reg   <= '0;
      cycle_count_reg <= '0;
      stg_reg         <= '0;
    end else begin
      state_reg       <= state_next;
      core_rst_reg    <= core_rst_next;
      busy_reg        <= busy_next;
      all_done_reg    <= all_done_next;
      timeout_reg     <= timeout_next;
      done_mask_reg   <= done_mask_next;
      cycle_count_reg <= cycle_count_next;
      stg_reg         <= stg_next;
    end
  end

  assign bus.core_rst    = core_rst_reg;
  assign bus.busy        = busy_reg;
  assign bus.all_done    = all_done_reg;
  assign bus.timeout     = timeout_reg;
  assign bus.done_mask   = done_mask_reg;
  assign bus.cycle_count = cycle_count_reg;

endmodule

// File: tb/tb_soc_boot_ctrl.sv
// ---------------------------------------------------------------------------
// tb_soc_boot_ctrl
// Scoreboard bench for soc_boot_ctrl (4 cores, stagger 16, 8-bit counter,
// timeout 100). Each step drives start/clr/core_done, pushes the expected
// post-edge status to a queue, and after the edge pops and compares it.
// Expectations track the watchdog macro SOC_BOOT_WDT_EN.
// ---------------------------------------------------------------------------
module tb_soc_boot_ctrl;

  localparam int NC  = 4;
  localparam int CW  = 8;
  localparam int STG = 16;
  localparam int TMO = 100;

`ifdef SOC_BOOT_WDT_EN
  localparam bit WDT = 1'b1;
`else
  localparam bit WDT = 1'b0;
`endif

  logic clk;
  logic rst;

  soc_boot_ctrl_if #(.NUM_CORES(NC), .CNT_W(CW)) bus_if ();

  soc_boot_ctrl #(
    .NUM_CORES      (NC),
    .STAGGER_CYCLES (STG),
    .CNT_W          (CW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] core_rst;
    logic       busy;
    logic       all_done;
    logic       timeout;
    logic [3:0] done_mask;
    logic [7:0] cnt;
    logic       care;      // 0: done_mask/cycle_count not checked
  } exp_t;

  exp_t exp_q[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] r, input logic b,
                              input logic a, input logic t,
                              input logic [3:0] m, input int c,
                              input logic care);
    exp_t e;
    e.core_rst  = r;
    e.busy      = b;
    e.all_done  = a;
    e.timeout   = t;
    e.done_mask = m;
    e.cnt       = 8'(c);
    e.care      = care;
    return e;
  endfunction

  // core_rst j edges after the start edge (stagger 16, 4 cores).
  function automatic logic [3:0] rst_pat(input int j);
    if (j < 16)      return 4'b1110;
    else if (j < 32) return 4'b1100;
    else if (j < 48) return 4'b1000;
    else             return 4'b0000;
  endfunction

  task automatic pop_compare(input string tag);
    exp_t e;
    check_val({tag, ".sbq"}, exp_q.size(), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val({tag, ".core_rst"}, bus_if.core_rst, e.core_rst);
      check_val({tag, ".busy"},     bus_if.busy,     e.busy);
      check_val({tag, ".all_done"}, bus_if.all_done, e.all_done);
      check_val({tag, ".timeout"},  bus_if.timeout,  e.timeout);
      if (e.care) begin
        check_val({tag, ".done_mask"},   bus_if.done_mask,   e.done_mask);
        check_val({tag, ".cycle_count"}, bus_if.cycle_count, e.cnt);
      end
    end
    $display("[%0t] %-6s core_rst=%b busy=%b all_done=%b timeout=%b done_mask=%b cycle_count=%0d",
             $time, tag, bus_if.core_rst, bus_if.busy, bus_if.all_done,
             bus_if.timeout, bus_if.done_mask, bus_if.cycle_count);
  endtask

  task automatic step(input logic s, input logic c, input logic [3:0] d,
                      input exp_t e, input string tag);
    bus_if.start     = s;
    bus_if.clr       = c;
    bus_if.core_done = d;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    bus_if.clr   = 1'b0;
    pop_compare(tag);
  endtask

  initial begin
    logic [3:0] d;
    logic [3:0] m;
    exp_t       e;

    rst              = 1'b1;
    bus_if.start     = 1'b0;
    bus_if.clr       = 1'b0;
    bus_if.core_done = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(mk(4'hF, 0, 0, 0, 4'h0, 0, 1));
    pop_compare("RST");
    rst = 1'b0;
    step(0, 0, 4'h0, mk(4'hF, 0, 0, 0, 4'h0, 0, 1), "IDLE");

    // Staggered release, completion, done in DONE, start ignored, start+clr.
    step(1, 0, 4'h0, mk(4'b1110, 1, 0, 0, 4'h0, 0, 1), "B0");
    for (int j = 1; j <= 52; j++) begin
      d = (j >= 10) ? 4'hF : 4'h0;
      if (j < 10)      m = 4'b0000;
      else if (j < 17) m = 4'b0001;
      else if (j < 33) m = 4'b0011;
      else if (j < 49) m = 4'b0111;
      else             m = 4'b1111;
      e = mk(rst_pat(j), j < 49, j >= 49, 0, m, (j < 49) ? j : 49, 1);
      step(0, 0, d, e, $sformatf("B%0d", j));
    end
    step(1, 0, 4'hF, mk(4'h0, 0, 1, 0, 4'hF, 49, 1), "BSTA");
    step(1, 1, 4'hF, mk(4'hF, 0, 0, 0, 4'h0, 0, 0), "BCLR");

    // No completion: watchdog to TMO, or free run into saturation.
    step(1, 0, 4'h0, mk(4'b1110, 1, 0, 0, 4'h0, 0, 1), "D0");
    for (int j = 1; j <= (WDT ? 110 : 258); j++) begin
      if (WDT && j >= TMO)
        e = mk(4'hF, 0, 0, 1, 4'h0, TMO, 1);
      else
        e = mk(rst_pat(j), 1, 0, 0, 4'h0, (j > 255) ? 255 : j, 1);
      step(j == 105, 0, 4'h0, e, $sformatf("D%0d", j));
    end
    step(0, 1, 4'h0, mk(4'hF, 0, 0, 0, 4'h0, 0, 0), "DCLR");

    // Final completion on the very cycle the count reaches the limit.
    step(1, 0, 4'b0111, mk(4'b1110, 1, 0, 0, 4'h0, 0, 1), "E0");
    for (int j = 1; j <= 102; j++) begin
      d = (j >= TMO) ? 4'hF : 4'b0111;
      if (j < 17)       m = 4'b0001;
      else if (j < 33)  m = 4'b0011;
      else if (j < TMO) m = 4'b0111;
      else              m = 4'b1111;
      e = mk(rst_pat(j), j < TMO, j >= TMO, 0, m, (j < TMO) ? j : TMO, 1);
      step(0, 0, d, e, $sformatf("E%0d", j));
    end
    step(0, 1, 4'h0, mk(4'hF, 0, 0, 0, 4'h0, 0, 0), "ECLR");

    // Asynchronous reset in the middle of RELEASE, then a clean restart.
    step(1, 0, 4'h0, mk(4'b1110, 1, 0, 0, 4'h0, 0, 1), "F0");
    for (int j = 1; j <= 19; j++)
      step(0, 0, 4'h0, mk(rst_pat(j), 1, 0, 0, 4'h0, j, 1), $sformatf("F%0d", j));
    #2;
    rst = 1'b1;
    exp_q.push_back(mk(4'hF, 0, 0, 0, 4'h0, 0, 1));
    #1;
    pop_compare("FARST");
    #1;
    rst = 1'b0;
    step(0, 0, 4'h0, mk(4'hF, 0, 0, 0, 4'h0, 0, 1), "FIDLE");
    step(1, 0, 4'h0, mk(4'b1110, 1, 0, 0, 4'h0, 0, 1), "G0");
    for (int j = 1; j <= 3; j++)
      step(0, 0, 4'h0, mk(4'b1110, 1, 0, 0, 4'h0, j, 1), $sformatf("G%0d", j));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/soc_boot_ctrl.md
SOC_BOOT_CTRL -- requirements
Module: soc_boot_ctrl

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, number of cores sequenced (1..16).
REQ-002 SHALL have parameter STAGGER_CYCLES, default 16, cycles between successive core reset releases (>=1).
REQ-003 SHALL have parameter CNT_W, default 32, width of the run-cycle counter.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 100000, watchdog limit in cycles (< 2^CNT_W).
REQ-005 SHALL have port clk  input  1  the single clock.
REQ-006 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-007 SHALL have port start  input  1  one-cycle boot request.
REQ-008 SHALL have port clr  input  1  one-cycle return-to-IDLE request.
REQ-009 SHALL have port core_done  input  NUM_CORES  per-core completion level.
REQ-010 SHALL have port core_rst  output  NUM_CORES  per-core reset, active-high.
REQ-011 SHALL have port busy  output  1  high in RELEASE and RUN.
REQ-012 SHALL have port all_done  output  1  high in DONE.
REQ-013 SHALL have port timeout  output  1  high in TMO.
REQ-014 SHALL have port done_mask  output  NUM_CORES  sticky per-core completion flags.
REQ-015 SHALL have port cycle_count  output  CNT_W  cycles elapsed since start.

Function
REQ-016 SHALL implement states IDLE, RELEASE, RUN, DONE, TMO; all outputs registered.
REQ-017 IDLE: core_rst all ones, busy/all_done/timeout 0; start moves to RELEASE and clears done_mask and cycle_count.
REQ-018 Edge leaving IDLE SHALL deassert core_rst[0]; core_rst[i] SHALL deassert exactly STAGGER_CYCLES*i edges later.
REQ-019 Once the last core is released, state SHALL move to RUN on the same edge.
REQ-020 NUM_CORES=1: IDLE SHALL go directly to RUN with core_rst[0] released.
REQ-021 cycle_count SHALL increment by 1 per cycle in RELEASE and RUN, saturate at all ones, hold in DONE/TMO.
REQ-022 done_mask[i] SHALL set when core_done[i]=1 and core_rst[i]=0; core_done from a core held in reset SHALL be ignored.
REQ-023 When done_mask (including bits set this cycle) is all ones, state SHALL move to DONE; cores stay released.
REQ-024 start in RELEASE, RUN, DONE or TMO SHALL be ignored.
REQ-025 clr in any state SHALL move to IDLE next edge, reassert all core_rst; clr beats start if both high.
REQ-026 Watchdog: cycle_count reaching TIMEOUT_CYCLES in RELEASE/RUN SHALL move to TMO and reassert all core_rst.
REQ-027 Last done bit and timeout on the same cycle: DONE SHALL win.

Reset
REQ-028 rst SHALL asynchronously force IDLE, core_rst all ones, busy/all_done/timeout 0, done_mask 0, cycle_count 0.
REQ-029 rst asserted mid-RELEASE or mid-RUN SHALL reassert all core_rst immediately, without waiting for clk.
REQ-030 After rst deasserts, the block SHALL wait in IDLE for start.

Configuration
REQ-031 Macro SOC_BOOT_WDT_EN defined: watchdog and TMO state per REQ-026/027.
REQ-032 Macro SOC_BOOT_WDT_EN undefined: no TMO state and timeout tied 0; RUN persists until all done or clr.

Verification
REQ-033 NUM_CORES=4, STAGGER=16, start at edge k -> core_rst 4'b1110 after k, 4'b1100 after k+16, 4'b1000 after k+32, 0 after k+48 (RUN).
REQ-034 core_done=4'b1111 at edge k+10 -> done_mask 4'b0001 only; all four held high through k+48 -> DONE, all_done=1, cycle_count frozen.
REQ-035 TIMEOUT_CYCLES=100, no core_done -> timeout=1 and core_rst=4'b1111 when cycle_count reaches 100; SOC_BOOT_WDT_EN undefined -> busy stays 1, timeout 0.
REQ-036 Last core_done on the cycle cycle_count reaches TIMEOUT_CYCLES -> DONE, timeout 0.
REQ-037 rst pulse during RELEASE at edge k+20 -> core_rst 4'b1111 before the next edge, state IDLE; a later start restarts with cycle_count from 0.
REQ-038 start and clr high together in DONE -> IDLE, core_rst 4'b1111, all_done 0.
